// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates a CPU port and a debug/loader port onto one data
// memory. Each access costs three cycles: grant (IDLE), memory access (ACCESS)
// and response (RESP). The CPU has fixed priority. The debug port is forced
// through once it has lost STARVE_MAX idle-cycle arbitrations in a row.
//
// Handshake (both ports): a requester raises req together with we/addr/
// wdata/funct3 and holds them until gnt. gnt is a single-cycle pulse,
// combinational from req while IDLE. The request fields are captured on the
// same rising edge. The memory sees the access for exactly one cycle after
// that, and the owner's rvalid/rdata pulse for one cycle after the access.
// req and fields are ignored while busy.
//
// Optional feature: define DMEM_ARB_MISALIGN_TRAP_EN to trap misaligned CPU
// half-word/word accesses. A trapped access is granted normally, but it never
// reaches the memory and it answers with cpu_err=1 and cpu_rdata=0. Without
// the macro every access is forwarded unchanged and cpu_err is always 0.
//
// fsm_state and starve_cnt are exported so checkers can observe the
// arbitration state directly.
module dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4,
    localparam int CNT_W     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              n_rst,

    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [2:0]        cpu_funct3,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic              cpu_err,
    output logic [31:0]       cpu_rdata,

    // debug / loader port
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    input  logic [2:0]        dbg_funct3,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,

    // data memory
    output logic              mem_MemWr,
    output logic              mem_MemRead,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_rdata,

    // status / observability
    output logic              busy,
    output logic [1:0]        fsm_state,
    output logic [CNT_W-1:0]  starve_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t state;

    // fields captured at grant time; lat_owner is 1 when the debug port owns
    // the access in flight
    logic              lat_owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [2:0]        lat_funct3;
    logic              lat_trap;

    logic              in_idle;
    logic              dbg_forced;
    logic              cpu_misaligned;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_wdata;
    logic [2:0]        win_funct3;
    logic              win_trap;
    logic [31:0]       resp_data;

    // grants are gated by n_rst so that every output reads 0 during reset,
    // even when a requester is already holding req
    assign in_idle    = n_rst && (state == IDLE);
    assign dbg_forced = (starve_cnt == STARVE_LIM);

    assign cpu_gnt = in_idle && cpu_req && !(dbg_req && dbg_forced);
    assign dbg_gnt = in_idle && dbg_req && (!cpu_req || dbg_forced);

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    // half-word (lh/lhu/sh) needs addr[0]=0; word (lw/sw) needs addr[1:0]=0
    assign cpu_misaligned =
        (((cpu_funct3 == 3'd1) || (cpu_funct3 == 3'd5)) && cpu_addr[0]) ||
        ((cpu_funct3 == 3'd2) && (cpu_addr[1:0] != 2'b00));
`else
    assign cpu_misaligned = 1'b0;
`endif

    // request fields of whichever port wins this idle cycle
    assign win_we     = dbg_gnt ? dbg_we     : cpu_we;
    assign win_addr   = dbg_gnt ? dbg_addr   : cpu_addr;
    assign win_wdata  = dbg_gnt ? dbg_wdata  : cpu_wdata;
    assign win_funct3 = dbg_gnt ? dbg_funct3 : cpu_funct3;
    assign win_trap   = cpu_gnt && cpu_misaligned;

    // writes and trapped accesses answer with zero data; reads take the
    // memory's combinational output during ACCESS
    assign resp_data = (lat_we || lat_trap) ? 32'h0 : mem_rdata;

    assign busy      = (state != IDLE);
    assign fsm_state = state;

    // main FSM: captures the winner, drives the memory for one cycle, then
    // returns the response to the owner for one cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            lat_owner   <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= 32'h0;
            lat_funct3  <= 3'd0;
            lat_trap    <= 1'b0;
            mem_MemWr   <= 1'b0;
            mem_MemRead <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0;
            mem_funct3  <= 3'd0;
            cpu_rvalid  <= 1'b0;
            cpu_err     <= 1'b0;
            cpu_rdata   <= 32'h0;
            dbg_rvalid  <= 1'b0;
            dbg_rdata   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_gnt || dbg_gnt) begin
                        state       <= ACCESS;
                        lat_owner   <= dbg_gnt;
                        lat_we      <= win_we;
                        lat_addr    <= win_addr;
                        lat_wdata   <= win_wdata;
                        lat_funct3  <= win_funct3;
                        lat_trap    <= win_trap;
                        // a trapped access keeps both enables low so the
                        // memory is never touched
                        mem_MemWr   <= win_we && !win_trap;
                        mem_MemRead <= !win_we && !win_trap;
                        mem_addr    <= win_addr;
                        mem_wdata   <= win_wdata;
                        mem_funct3  <= win_funct3;
                    end
                end

                ACCESS: begin
                    state       <= RESP;
                    mem_MemWr   <= 1'b0;
                    mem_MemRead <= 1'b0;
                    mem_addr    <= '0;
                    mem_wdata   <= 32'h0;
                    mem_funct3  <= 3'd0;
                    if (lat_owner) begin
                        dbg_rvalid <= 1'b1;
                        dbg_rdata  <= resp_data;
                    end else begin
                        cpu_rvalid <= 1'b1;
                        cpu_err    <= lat_trap;
                        cpu_rdata  <= resp_data;
                    end
                end

                RESP: begin
                    state      <= IDLE;
                    cpu_rvalid <= 1'b0;
                    cpu_err    <= 1'b0;
                    cpu_rdata  <= 32'h0;
                    dbg_rvalid <= 1'b0;
                    dbg_rdata  <= 32'h0;
                end

                default: begin
                    state       <= IDLE;
                    mem_MemWr   <= 1'b0;
                    mem_MemRead <= 1'b0;
                    cpu_rvalid  <= 1'b0;
                    cpu_err     <= 1'b0;
                    dbg_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    // starvation counter: counts idle arbitrations the debug port lost to the
    // CPU, saturating at STARVE_MAX, and clears whenever debug wins
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            starve_cnt <= '0;
        end else if (dbg_gnt) begin
            starve_cnt <= '0;
        end else if (cpu_gnt && dbg_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule
